pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 27 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline stage register.
package pipe_pkg;

  // FULL is the single occupied state of the non-skid build.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam stage_state_e FULL = ONE;

  localparam int unsigned DEF_CTRL_W = 10;
  localparam int unsigned DEF_DATA_W = 175;

  // ID/EX control bundle field offsets.
  localparam int unsigned CTRL_REGWRITE     = 0;
  localparam int unsigned CTRL_MEMWRITE     = 1;
  localparam int unsigned CTRL_ALUSRC       = 2;
  localparam int unsigned CTRL_BRANCH       = 3;
  localparam int unsigned CTRL_JUMP         = 4;
  localparam int unsigned CTRL_RESULTSRC_LO = 5;
  localparam int unsigned CTRL_RESULTSRC_W  = 2;
  localparam int unsigned CTRL_ALUCTRL_LO   = 7;
  localparam int unsigned CTRL_ALUCTRL_W    = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush-to-bubble and stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W              = DEF_CTRL_W,
  parameter int unsigned DATA_W              = DEF_DATA_W,
  parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W               = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      r_state;
  stage_state_e      w_state_d;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_main;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_load_skid;
  logic              w_skid_to_main;

  // Registered-state decode only: no combinational path from out_ready.
  assign w_in_ready = (r_state != TWO);

  always_comb begin
    w_state_d      = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_d   = ONE;
          w_load_main = 1'b1;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main = 1'b1;
        end else if (w_in_fire) begin
          w_state_d   = TWO;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_d = EMPTY;
        end
      end
      TWO: begin
        if (w_out_fire) begin
          w_state_d      = ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: w_state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_skid_ctrl <= '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        r_skid_data <= '0;
      end
    end else if (w_load_skid) begin
      r_skid_ctrl <= in_ctrl;
      r_skid_data <= in_data;
    end
  end
`else
  assign w_in_ready = ~w_out_valid | out_ready;

  always_comb begin
    w_state_d   = r_state;
    w_load_main = 1'b0;
    if (w_in_fire) begin
      w_state_d   = FULL;
      w_load_main = 1'b1;
    end else if (w_out_fire) begin
      w_state_d = EMPTY;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main_ctrl <= '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        r_main_data <= '0;
      end
    end else begin
      r_state <= w_state_d;
      if (w_load_main) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end
`ifdef PIPE_STAGE_SKID_EN
      else if (w_skid_to_main) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
`endif
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_valid & ~w_in_ready),
    .count (stall_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; follows PIPE_STAGE_SKID_EN like the RTL.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 175;
  localparam int unsigned NW = 4;
  localparam int unsigned SatMax = 15;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt;

  int            n_checks = 0;
  int            n_pass = 0;
  beat_t         m_q[$];
  logic [DW-1:0] m_hold;
  int unsigned   m_stall;
  int            n_accepted;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W              (CW),
    .DATA_W              (DW),
    .CLEAR_DATA_ON_FLUSH (1'b1),
    .CNT_W               (NW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // One cycle: drive at negedge, check just after, update model, advance to next negedge.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl, input logic rs);
    logic  m_ready;
    beat_t b;
    rst = rs; flush = fl; in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy;
    #1;
    n_accepted = 0;
    if (rs) begin
      m_q.delete();
      m_hold  = '0;
      m_stall = 0;
    end else begin
      m_ready = Skid ? (m_q.size() < 2) : ((m_q.size() == 0) || ordy);
      check_eq("in_ready", {191'd0, in_ready}, {191'd0, m_ready});
      check_eq("out_valid", {191'd0, out_valid}, {191'd0, m_q.size() != 0});
      check_eq("out_ctrl", {182'd0, out_ctrl}, (m_q.size() != 0) ? {182'd0, m_q[0].ctrl} : '0);
      check_eq("out_data", {17'd0, out_data},
               (m_q.size() != 0) ? {17'd0, m_q[0].data} : {17'd0, m_hold});
      check_eq("stall_cnt", {188'd0, stall_cnt}, 192'(m_stall));
      if ((m_q.size() != 0) && ordy) begin
        b = m_q.pop_front();
        m_hold = b.data;
      end
      if (v && m_ready) n_accepted = 1;
      if (v && m_ready && !fl) begin
        b.ctrl = c;
        b.data = d;
        m_q.push_back(b);
      end
      if (fl) begin
        m_q.delete();
        m_hold = '0;
      end
      if (v && !m_ready && (m_stall != SatMax)) m_stall++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 10'h3FF, {DW{1'b1}}, 1'b1, 1'b0, 1'b1);
  endtask

  // Offer beats base..base+n-1, each held until accepted; out_ready low for the first hold_cyc.
  task automatic send(input int base, input int n, input int hold_cyc);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 60) begin
      step(1'b1, CW'(base + idx) ^ 10'h155, DW'(base + idx), (cyc >= hold_cyc), 1'b0, 1'b0);
      idx += n_accepted;
      cyc++;
    end
    check_eq("send_timeout", 192'(idx), 192'(n));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    m_hold = '0; m_stall = 0; n_accepted = 0;
    @(negedge clk);

    // Reset with in_valid held high, then check idle outputs.
    do_reset(2);
    idle(1, 1'b0);

    // Back-to-back streaming 1..8.
    send(1, 8, 0);
    idle(3, 1'b1);

    // Back-pressure: three beats with out_ready low for six cycles.
    do_reset(1);
    send(1, 3, 6);
    idle(4, 1'b1);

    // Flush with stored beats and a live input beat carrying all-ones ctrl.
    do_reset(1);
    send(20, 2, 10);
    step(1'b1, 10'h3FF, DW'(99), 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Flush coinciding with an out_fire of the head beat.
    send(30, 1, 0);
    step(1'b1, 10'h2AA, DW'(77), 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Stall counter saturation.
    do_reset(1);
    for (int i = 0; i < 40; i++) step(1'b1, 10'h011, DW'(500 + i), 1'b0, 1'b0, 1'b0);
    check_eq("stall_sat", {188'd0, stall_cnt}, 192'(SatMax));
    idle(3, 1'b1);

    // Randomised traffic with occasional flushes.
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, CW'($urandom),
           DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, 1'b0);
    end
    idle(4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
